// File: rtl/adder_tree_pkg.sv
// Shared types and default widths for the adder-tree accumulator slice.
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DEF = 48;
  localparam int ACC_EXTRA_DEF   = 16;
  localparam int MAX_BEATS_DEF   = 1024;
  localparam int SUM_W_DEF       = ADDER_WIDTH_DEF + 1;
  localparam int ACC_W_DEF       = SUM_W_DEF + ACC_EXTRA_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/adder_tree_acc_core.sv
// Accumulator datapath: acc/beats/ovf registers with a carry-detecting add.
// The *_next outputs give the totals including the beat being added this cycle.
module adder_tree_acc_core #(
  parameter int SUM_W   = 49,
  parameter int ACC_W   = 65,
  parameter int BEATS_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [SUM_W-1:0]   in_sum,
  output logic [ACC_W-1:0]   acc_next,
  output logic [BEATS_W-1:0] beats_next,
  output logic               ovf_next
);

  logic [ACC_W-1:0]   acc;
  logic [BEATS_W-1:0] beats;
  logic               ovf;
  logic [ACC_W-1:0]   acc_base;
  logic [BEATS_W-1:0] beats_base;
  logic               ovf_base;
  logic [ACC_W:0]     sum_wide;

  // clear makes this cycle's add start a fresh frame
  always_comb begin
    acc_base   = clear ? '0 : acc;
    beats_base = clear ? '0 : beats;
    ovf_base   = clear ? 1'b0 : ovf;
    sum_wide   = {1'b0, acc_base} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
    acc_next   = sum_wide[ACC_W-1:0];
    beats_next = beats_base + BEATS_W'(1);
    ovf_next   = ovf_base | sum_wide[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      beats <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      acc   <= acc_next;
      beats <= beats_next;
      ovf   <= ovf_next;
    end else if (clear) begin
      acc   <= '0;
      beats <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: rtl/adder_tree_accumulator.sv
// Frame accumulator behind the adder tree: sums beats until last/MAX_BEATS, then holds the total.
// state | meaning: IDLE no beats yet | ACCUM at least one beat taken | HOLD total presented
module adder_tree_accumulator
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DEF,
  parameter int ACC_EXTRA    = ACC_EXTRA_DEF,
  parameter int MAX_BEATS    = MAX_BEATS_DEF,
  localparam int SUM_W       = ADDER_WIDTH + 1,
  localparam int ACC_W       = SUM_W + ACC_EXTRA,
  localparam int BEATS_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_sum,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic [BEATS_W-1:0] out_beats,
  output logic               out_ovf
);

  acc_state_t         state, state_next;
  logic               rdy_q;
  logic               accept;
  logic               frame_end;
  logic               clear;
  logic [ACC_W-1:0]   acc_next;
  logic [BEATS_W-1:0] beats_next;
  logic               ovf_next;

  adder_tree_acc_core #(
    .SUM_W   (SUM_W),
    .ACC_W   (ACC_W),
    .BEATS_W (BEATS_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .en         (accept),
    .in_sum     (in_sum),
    .acc_next   (acc_next),
    .beats_next (beats_next),
    .ovf_next   (ovf_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_next;
      rdy_q <= 1'b1;
    end
  end

  always_comb begin
    accept    = in_valid && in_ready;
    frame_end = accept && (in_last || (beats_next == BEATS_W'(MAX_BEATS)));
    clear     = (state == IDLE) || ((state == HOLD) && out_ready);
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (frame_end)   state_next = HOLD;
        else if (accept) state_next = ACCUM;
      end
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rdy_q keeps in_ready low through the reset cycle without depending on rst combinationally
  always_comb begin
    in_ready  = rdy_q && (state != HOLD);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_acc   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (frame_end) begin
      out_acc   <= acc_next;
      out_beats <= beats_next;
      out_ovf   <= ovf_next;
    end
  end

endmodule
